// File: rtl/mm_arb2_if.sv
`default_nettype none
// ============================================================================
//  Module   : mm_arb2_if
//  Brief    : CPU-style memory-mapped bus (a/d/we/rd pulse, spo/ready back).
//  Revision : 1.0  initial release
// ============================================================================
interface mm_arb2_if;
  logic [31:0] a;
  logic [31:0] d;
  logic        we;
  logic        rd;
  logic [31:0] spo;
  logic        ready;

  // master issues requests; slave answers with spo/ready
  modport master (output a, d, we, rd, input spo, ready);
  modport slave  (input a, d, we, rd, output spo, ready);
endinterface
`default_nettype wire

// File: rtl/mm_arb2.sv
`default_nettype none
// ============================================================================
//  Module   : mm_arb2
//  Brief    : Two-port round-robin (or fixed-priority) arbiter onto one
//             memory-mapped bus target; one latched request per port.
//  Revision : 1.0  initial release
// ============================================================================
module mm_arb2 #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic      clk,
  input  logic      rst,
  mm_arb2_if.slave  s0,
  mm_arb2_if.slave  s1,
  mm_arb2_if.master m
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [1:0]       w_req;
  logic [1:0]       w_req_rd;
  logic [1:0][31:0] w_req_a;
  logic [1:0][31:0] w_req_d;
  logic [1:0]       w_accept;

  logic [1:0]       r_pend;
  logic [1:0]       r_pend_rd;
  logic [1:0][31:0] r_pend_a;
  logic [1:0][31:0] r_pend_d;
  logic [1:0]       r_inflight;
  logic [1:0][31:0] r_spo;

  logic             r_last;
  logic             r_gnt;
  logic             r_op_rd;
  logic [31:0]      r_m_a;
  logic [31:0]      r_m_d;

  logic             w_grant_vld;
  logic             w_grant;
  logic             w_done;
  logic [1:0]       w_grant_oh;
  logic [1:0]       w_done_oh;

  // rd dominates we when both pulse together
  assign w_req    = {s1.rd | s1.we, s0.rd | s0.we};
  assign w_req_rd = {s1.rd, s0.rd};
  assign w_req_a  = {s1.a, s0.a};
  assign w_req_d  = {s1.d, s0.d};
  assign w_accept = w_req & ~r_pend & ~r_inflight;

  always_comb begin
    w_state_nxt = r_state;
    w_grant_vld = 1'b0;
    w_grant     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|r_pend) begin
          w_grant_vld = 1'b1;
          if (r_pend == 2'b11) begin
            w_grant = FIXED_PRIO ? 1'b0 : ~r_last;
          end else begin
            w_grant = r_pend[1];
          end
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (m.ready) begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_grant_oh = {w_grant_vld & w_grant, w_grant_vld & ~w_grant};
  assign w_done_oh  = {w_done & r_gnt, w_done & ~r_gnt};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A port never has accept and grant in the same cycle: accept needs !pend.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend     <= '0;
      r_pend_rd  <= '0;
      r_pend_a   <= '0;
      r_pend_d   <= '0;
      r_inflight <= '0;
      r_spo      <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_accept[i]) begin
          r_pend[i]    <= 1'b1;
          r_pend_rd[i] <= w_req_rd[i];
          r_pend_a[i]  <= w_req_a[i];
          r_pend_d[i]  <= w_req_d[i];
        end else if (w_grant_oh[i]) begin
          r_pend[i]    <= 1'b0;
        end
        if (w_grant_oh[i]) begin
          r_inflight[i] <= 1'b1;
        end else if (w_done_oh[i]) begin
          r_inflight[i] <= 1'b0;
        end
        if (w_done_oh[i] && r_op_rd) begin
          r_spo[i] <= m.spo;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last  <= 1'b1;
      r_gnt   <= 1'b0;
      r_op_rd <= 1'b0;
      r_m_a   <= '0;
      r_m_d   <= '0;
    end else if (w_grant_vld) begin
      r_last  <= w_grant;
      r_gnt   <= w_grant;
      r_op_rd <= r_pend_rd[w_grant];
      r_m_a   <= r_pend_a[w_grant];
      r_m_d   <= r_pend_d[w_grant];
    end
  end

  assign m.a  = r_m_a;
  assign m.d  = r_m_d;
  assign m.rd = (r_state == ST_ISSUE) &  r_op_rd;
  assign m.we = (r_state == ST_ISSUE) & ~r_op_rd;

  assign s0.spo   = r_spo[0];
  assign s1.spo   = r_spo[1];
  assign s0.ready = ~r_pend[0] & ~r_inflight[0] & ~w_req[0];
  assign s1.ready = ~r_pend[1] & ~r_inflight[1] & ~w_req[1];

endmodule
`default_nettype wire

// File: tb/tb_mm_arb2.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mm_arb2
//  Brief    : Bench for mm_arb2; instance 0 round-robin, instance 1 fixed.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mm_arb2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0][1:0]       in_rd, in_we, st_rd, st_we;
  logic [1:0][1:0][31:0] in_a, in_d, st_a, st_d;
  logic [1:0][1:0][31:0] obs_spo;
  logic [1:0][1:0]       obs_rdy;
  logic [1:0][31:0]      obs_ma, obs_md;
  logic [1:0]            obs_mrd, obs_mwe, obs_mready;
  int                    lat_cfg [2];

  function automatic logic [31:0] tgt_data(input logic [31:0] a);
    return (a == 32'h0000_1000) ? 32'hDEAD_BEEF : {a[15:0] ^ 16'h5A5A, ~a[31:16]};
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    mm_arb2_if s0_if ();
    mm_arb2_if s1_if ();
    mm_arb2_if m_if ();
    logic [2:0]  cnt;
    logic [31:0] rdata;

    assign s0_if.a  = in_a[gi][0];
    assign s0_if.d  = in_d[gi][0];
    assign s0_if.rd = in_rd[gi][0];
    assign s0_if.we = in_we[gi][0];
    assign s1_if.a  = in_a[gi][1];
    assign s1_if.d  = in_d[gi][1];
    assign s1_if.rd = in_rd[gi][1];
    assign s1_if.we = in_we[gi][1];
    assign obs_spo[gi][0] = s0_if.spo;
    assign obs_spo[gi][1] = s1_if.spo;
    assign obs_rdy[gi][0] = s0_if.ready;
    assign obs_rdy[gi][1] = s1_if.ready;
    assign obs_ma[gi]     = m_if.a;
    assign obs_md[gi]     = m_if.d;
    assign obs_mrd[gi]    = m_if.rd;
    assign obs_mwe[gi]    = m_if.we;
    assign obs_mready[gi] = m_if.ready;

    // downstream target: busy for a configurable number of cycles after a pulse
    assign m_if.ready = !(m_if.rd || m_if.we) && (cnt == 3'd0);
    assign m_if.spo   = rdata;
    always @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt   <= 3'd0;
        rdata <= 32'd0;
      end else if (m_if.rd || m_if.we) begin
        cnt <= (lat_cfg[gi] < 0) ? 3'($urandom_range(0, 3)) : 3'(lat_cfg[gi]);
        if (m_if.rd) rdata <= tgt_data(m_if.a);
      end else if (cnt != 3'd0) begin
        cnt <= cnt - 3'd1;
      end
    end

    mm_arb2 #(.FIXED_PRIO(gi == 1)) u_dut (
      .clk (clk),
      .rst (rst),
      .s0  (s0_if),
      .s1  (s1_if),
      .m   (m_if)
    );
  end

  // transaction-level reference state, indexed [instance][port]
  bit          outst  [2][2];
  bit          issued [2][2];
  bit          q_rd   [2][2];
  logic [31:0] q_a    [2][2];
  logic [31:0] q_d    [2][2];
  int          q_cyc  [2][2];
  logic [31:0] exp_spo[2][2];
  bit          busy   [2];
  int          cur    [2];
  int          last_gnt [2];
  int          last_done[2];
  int          t;
  int          checks;
  int          errors;

  task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s inst%0d cyc%0d: observed %h expected %h", tag, i, t, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int p = 0; p < 2; p++) begin
        outst[i][p]   = 1'b0;
        issued[i][p]  = 1'b0;
        exp_spo[i][p] = 32'd0;
      end
      busy[i]      = 1'b0;
      last_gnt[i]  = 1;
      last_done[i] = -100;
    end
  endtask

  task automatic check_cycle();
    for (int i = 0; i < 2; i++) begin
      bit   acc [2];
      bit   c0, c1;
      int   w;
      logic erd, ewe;
      for (int p = 0; p < 2; p++) begin
        acc[p] = (in_rd[i][p] || in_we[i][p]) && !outst[i][p];
        chk($sformatf("s%0d_ready", p), i, 32'(obs_rdy[i][p]),
            32'(!outst[i][p] && !(in_rd[i][p] || in_we[i][p])));
        chk($sformatf("s%0d_spo", p), i, obs_spo[i][p], exp_spo[i][p]);
      end
      erd = 1'b0;
      ewe = 1'b0;
      if (busy[i]) begin
        chk("m_a_hold", i, obs_ma[i], q_a[i][cur[i]]);
        chk("m_d_hold", i, obs_md[i], q_d[i][cur[i]]);
        if (obs_mready[i]) begin
          busy[i]      = 1'b0;
          last_done[i] = t;
          outst[i][cur[i]] = 1'b0;
          if (q_rd[i][cur[i]]) exp_spo[i][cur[i]] = tgt_data(q_a[i][cur[i]]);
        end
      end else if (t >= last_done[i] + 2) begin
        c0 = outst[i][0] && !issued[i][0] && (q_cyc[i][0] <= t - 2);
        c1 = outst[i][1] && !issued[i][1] && (q_cyc[i][1] <= t - 2);
        if (c0 || c1) begin
          if (c0 && c1) w = (i == 1) ? 0 : 1 - last_gnt[i];
          else          w = c0 ? 0 : 1;
          erd = q_rd[i][w];
          ewe = !q_rd[i][w];
          issued[i][w] = 1'b1;
          busy[i]      = 1'b1;
          cur[i]       = w;
          last_gnt[i]  = w;
          chk("m_a_issue", i, obs_ma[i], q_a[i][w]);
          chk("m_d_issue", i, obs_md[i], q_d[i][w]);
        end
      end
      chk("m_rd", i, 32'(obs_mrd[i]), 32'(erd));
      chk("m_we", i, 32'(obs_mwe[i]), 32'(ewe));
      for (int p = 0; p < 2; p++) begin
        if (acc[p]) begin
          outst[i][p]  = 1'b1;
          issued[i][p] = 1'b0;
          q_rd[i][p]   = in_rd[i][p];
          q_a[i][p]    = in_a[i][p];
          q_d[i][p]    = in_d[i][p];
          q_cyc[i][p]  = t;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    in_rd = st_rd;
    in_we = st_we;
    in_a  = st_a;
    in_d  = st_d;
    st_rd = '0;
    st_we = '0;
    @(negedge clk);
    check_cycle();
    t++;
  endtask

  task automatic req(input int i, input int p, input bit rd, input bit we,
                     input logic [31:0] a, input logic [31:0] d);
    st_rd[i][p] = rd;
    st_we[i][p] = we;
    st_a[i][p]  = a;
    st_d[i][p]  = d;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic wait_idle(input int max);
    for (int k = 0; k < max; k++) begin
      tick();
      if ((&obs_rdy) && !busy[0] && !busy[1]) break;
    end
    chk("drain", 0, 32'(&obs_rdy), 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    for (int i = 0; i < 2; i++) begin
      for (int p = 0; p < 2; p++) begin
        chk({tag, "_ready"}, i, 32'(obs_rdy[i][p]), 32'd1);
        chk({tag, "_spo"}, i, obs_spo[i][p], 32'd0);
      end
      chk({tag, "_m_rd"}, i, 32'(obs_mrd[i]), 32'd0);
      chk({tag, "_m_we"}, i, 32'(obs_mwe[i]), 32'd0);
      chk({tag, "_m_a"}, i, obs_ma[i], 32'd0);
      chk({tag, "_m_d"}, i, obs_md[i], 32'd0);
    end
  endtask

  initial begin
    int op;
    checks = 0;
    errors = 0;
    t      = 0;
    in_rd = '0; in_we = '0; in_a = '0; in_d = '0;
    st_rd = '0; st_we = '0; st_a = '0; st_d = '0;
    lat_cfg[0] = 2;
    lat_cfg[1] = 2;
    model_reset();

    rst = 1'b1;
    #12;
    check_reset_vals("rst_init");
    @(negedge clk);
    rst = 1'b0;
    idle(3);

    // port 0 read of 0x1000, target answers three cycles after the pulse
    for (int i = 0; i < 2; i++) req(i, 0, 1'b1, 1'b0, 32'h0000_1000, 32'h0);
    tick();
    wait_idle(20);
    for (int i = 0; i < 2; i++) chk("s0_deadbeef", i, obs_spo[i][0], 32'hDEAD_BEEF);

    // port 1 read, then write: the write must leave s1_spo alone
    for (int i = 0; i < 2; i++) req(i, 1, 1'b1, 1'b0, 32'h0000_3000, 32'h0);
    tick();
    wait_idle(20);
    for (int i = 0; i < 2; i++) req(i, 1, 1'b0, 1'b1, 32'h0000_2004, 32'h55AA_55AA);
    tick();
    wait_idle(20);
    for (int i = 0; i < 2; i++) chk("s1_spo_kept", i, obs_spo[i][1], tgt_data(32'h0000_3000));

    // simultaneous reads, three rounds
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 2; i++) begin
        req(i, 0, 1'b1, 1'b0, 32'h0000_0100 + 32'(r * 4), 32'h0);
        req(i, 1, 1'b1, 1'b0, 32'h0000_0200 + 32'(r * 4), 32'h0);
      end
      tick();
      wait_idle(30);
    end

    // port 0 served last, then contention: round-robin picks 1, fixed picks 0
    for (int i = 0; i < 2; i++) req(i, 0, 1'b1, 1'b0, 32'h0000_0300, 32'h0);
    tick();
    wait_idle(20);
    for (int i = 0; i < 2; i++) begin
      req(i, 0, 1'b1, 1'b0, 32'h0000_0400, 32'h0);
      req(i, 1, 1'b1, 1'b0, 32'h0000_0500, 32'h0);
    end
    idle(3);
    chk("contend_rr_m_a", 0, obs_ma[0], 32'h0000_0500);
    chk("contend_fp_m_a", 1, obs_ma[1], 32'h0000_0400);
    wait_idle(30);

    // repeated pulse while in flight is dropped; rd+we together issues only rd
    lat_cfg[0] = 3;
    lat_cfg[1] = 3;
    for (int i = 0; i < 2; i++) req(i, 0, 1'b1, 1'b0, 32'h0000_0600, 32'h0);
    tick();
    for (int i = 0; i < 2; i++) req(i, 0, 1'b1, 1'b0, 32'h0000_4444, 32'h0);
    tick();
    idle(2);
    for (int i = 0; i < 2; i++) req(i, 0, 1'b1, 1'b1, 32'h0000_4448, 32'h1);
    tick();
    wait_idle(20);
    for (int i = 0; i < 2; i++) req(i, 1, 1'b1, 1'b1, 32'h0000_5000, 32'h77);
    tick();
    wait_idle(20);
    for (int i = 0; i < 2; i++) chk("s0_first_result", i, obs_spo[i][0], tgt_data(32'h0000_0600));

    // port 1 write pulsed in the completion cycle of port 0's read
    lat_cfg[0] = 2;
    lat_cfg[1] = 2;
    for (int i = 0; i < 2; i++) req(i, 0, 1'b1, 1'b0, 32'h0000_1000, 32'h0);
    tick();
    idle(4);
    for (int i = 0; i < 2; i++) req(i, 1, 1'b0, 1'b1, 32'h0000_2008, 32'h1234_5678);
    tick();
    idle(2);
    for (int i = 0; i < 2; i++) begin
      chk("late_we", i, 32'(obs_mwe[i]), 32'd1);
      chk("late_we_addr", i, obs_ma[i], 32'h0000_2008);
    end
    wait_idle(20);

    // randomized traffic, including protocol violations
    lat_cfg[0] = -1;
    lat_cfg[1] = -1;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 2; i++) begin
        for (int p = 0; p < 2; p++) begin
          if ($urandom_range(0, 3) == 0) begin
            op = int'($urandom_range(0, 2));
            req(i, p, op != 1, op != 0, $urandom & 32'h0000_FFFC, $urandom);
          end
        end
      end
      tick();
    end
    wait_idle(60);

    // asynchronous reset in the middle of a WAIT phase
    lat_cfg[0] = 3;
    lat_cfg[1] = 3;
    for (int i = 0; i < 2; i++) req(i, 0, 1'b1, 1'b0, 32'h0000_6000, 32'hABCD);
    tick();
    idle(3);
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals("rst_wait");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    idle(3);
    for (int i = 0; i < 2; i++) req(i, 1, 1'b1, 1'b0, 32'h0000_7000, 32'h0);
    tick();
    wait_idle(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
